tdm_frame_serializer: RTL and testbench

Parametrised TDM serializer, successor to the fixed 3×8-bit encoder. It accepts a frame of `N_CH` channel words per transfer through a valid/ready handshake and holds it in a one-deep shadow buffer. It shifts each frame out bit-serially with a frame-start sync pulse, an optional guard gap between frames, and selectable bit order. It sits between the sample-producing logic and the serial line driver.

---
 rtl/tdm_pkg.sv | 20 ++
 rtl/tdm_frame_buffer.sv | 32 +++
 rtl/tdm_frame_serializer.sv | 136 +++++++++++++
 tb/tb_tdm_frame_serializer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and sizing helpers for the TDM frame serializer
// Contents: state_t (IDLE/DATA/GAP), frame_bits(), cnt_width()
package tdm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int frame_bits(input int n_ch, input int ch_w);
        return n_ch * ch_w;
    endfunction

    // Bits needed to count 0..n-1, never less than one so ports stay legal.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_frame_buffer.sv
// rtl/tdm_frame_buffer.sv - one-deep shadow register with valid/ready input handshake
// Ports: clk, rst_n (async, active-low), in_data/in_valid/in_ready (upstream handshake),
//        load (strobe: shadow consumed), full/data (shadow state toward the serializer)
module tdm_frame_buffer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         load,
    output logic         full,
    output logic [W-1:0] data
);

    assign in_ready = !full;

    // load only happens while full, so it never coincides with a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (load) begin
            full <= 1'b0;
        end else if (in_valid && !full) begin
            full <= 1'b1;
            data <= in_data;
        end
    end

endmodule

// File: rtl/tdm_frame_serializer.sv
// rtl/tdm_frame_serializer.sv - bit-serial TDM frame output with sync, guard gap and underrun repeat
// Ports: clk, rst_n (async, active-low), en, in_data/in_valid/in_ready (frame input),
//        serial_out, sync_pulse, ch_idx, underrun (all registered)
module tdm_frame_serializer
    import tdm_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int CH_W      = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP_BITS  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N_CH*CH_W-1:0]       in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       serial_out,
    output logic                       sync_pulse,
    output logic [cnt_width(N_CH)-1:0] ch_idx,
    output logic                       underrun
);

    localparam int FW    = frame_bits(N_CH, CH_W);
    localparam int CNT_W = cnt_width(FW);
    localparam int GAP_W = cnt_width(GAP_BITS);
    localparam int CIW   = cnt_width(N_CH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FW - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    state_t           state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_n;
    logic [GAP_W-1:0] gap_cnt, gap_n;
    logic [FW-1:0]    active, active_n, shadow, shifted;
    logic             shadow_full, load, underrun_n, boundary;
    logic [CIW-1:0]   ch_n;
    int               bit_pos, ch_num, sel_idx;

    tdm_frame_buffer #(.W(FW)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .load     (load),
        .full     (shadow_full),
        .data     (shadow)
    );

    // state/bit_cnt describe the bit currently on the line; the *_n values
    // describe the next one, and the output registers are fed from them so
    // every output changes on the same edge as the state it reflects.
    always_comb begin
        state_n    = state;
        bit_n      = bit_cnt;
        gap_n      = gap_cnt;
        active_n   = active;
        load       = 1'b0;
        underrun_n = 1'b0;
        boundary   = 1'b0;
        case (state)
            IDLE: begin
                if (en && shadow_full) begin
                    load     = 1'b1;
                    active_n = shadow;
                    state_n  = DATA;
                    bit_n    = '0;
                end
            end
            DATA: begin
                if (bit_cnt != LAST_BIT) begin
                    bit_n = bit_cnt + 1'b1;
                end else if (GAP_BITS > 0) begin
                    state_n = GAP;
                    gap_n   = '0;
                end else begin
                    boundary = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt != LAST_GAP) gap_n = gap_cnt + 1'b1;
                else                     boundary = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // Frame boundary: stop, take fresh data, or repeat the old frame.
        if (boundary) begin
            bit_n = '0;
            if (!en) begin
                state_n = IDLE;
            end else if (shadow_full) begin
                load     = 1'b1;
                active_n = shadow;
                state_n  = DATA;
            end else begin
                state_n    = DATA;
                underrun_n = 1'b1;
            end
        end
    end

    // Bit selection for the next line bit: channel = bit / CH_W, then the
    // position within the word is mirrored for MSB-first order.
    always_comb begin
        bit_pos = int'(bit_n);
        ch_num  = bit_pos / CH_W;
        if (MSB_FIRST != 0) sel_idx = ch_num * CH_W + (CH_W - 1 - (bit_pos % CH_W));
        else                sel_idx = ch_num * CH_W + (bit_pos % CH_W);
        shifted = active_n >> sel_idx;
        ch_n    = CIW'(ch_num);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            active     <= '0;
            serial_out <= 1'b0;
            sync_pulse <= 1'b0;
            underrun   <= 1'b0;
            ch_idx     <= '0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_n;
            gap_cnt    <= gap_n;
            active     <= active_n;
            serial_out <= (state_n == DATA) && shifted[0];
            sync_pulse <= (state_n == DATA) && (bit_n == '0);
            underrun   <= underrun_n;
            ch_idx     <= (state_n == DATA) ? ch_n : '0;
        end
    end

endmodule

// File: tb/tb_tdm_frame_serializer.sv
// tb/tb_tdm_frame_serializer.sv - directed self-checking bench for tdm_frame_serializer
module tb_tdm_frame_serializer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [23:0] in_data;
    logic        in_valid;
    logic [1:0]  sel;

    logic       d_ready, d_serial, d_sync, d_under;
    logic       l_ready, l_serial, l_sync, l_under;
    logic       g_ready, g_serial, g_sync, g_under;
    logic [1:0] d_ch, l_ch, g_ch;

    logic       obs_ready, obs_serial, obs_sync, obs_under;
    logic [1:0] obs_ch;

    int checks = 0;
    int errors = 0;

    tdm_frame_serializer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(d_ready), .serial_out(d_serial), .sync_pulse(d_sync),
        .ch_idx(d_ch), .underrun(d_under)
    );

    tdm_frame_serializer #(.MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_ready), .serial_out(l_serial), .sync_pulse(l_sync),
        .ch_idx(l_ch), .underrun(l_under)
    );

    tdm_frame_serializer #(.GAP_BITS(4)) dut_gap (
        .clk(clk), .rst_n(rst_n), .en(en), .in_data(in_data), .in_valid(in_valid),
        .in_ready(g_ready), .serial_out(g_serial), .sync_pulse(g_sync),
        .ch_idx(g_ch), .underrun(g_under)
    );

    always_comb begin
        obs_ready  = d_ready;
        obs_serial = d_serial;
        obs_sync   = d_sync;
        obs_under  = d_under;
        obs_ch     = d_ch;
        case (sel)
            2'd1: begin
                obs_ready = l_ready; obs_serial = l_serial; obs_sync = l_sync;
                obs_under = l_under; obs_ch = l_ch;
            end
            2'd2: begin
                obs_ready = g_ready; obs_serial = g_serial; obs_sync = g_sync;
                obs_under = g_under; obs_ch = g_ch;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered in the bit-0 cycle of a frame; leaves in the cycle after the
    // frame (and its gap). exp_bits holds the line bits in time order, MSB first.
    task automatic frame_check(input string tag, input logic [23:0] exp_bits,
                               input logic exp_under, input logic offer,
                               input logic [23:0] offer_data, input int drop_at,
                               input int gap);
        for (int i = 0; i < 24; i++) begin
            check($sformatf("%s b%0d serial", tag, i), 32'(obs_serial), 32'(exp_bits[23-i]));
            check($sformatf("%s b%0d sync", tag, i), 32'(obs_sync), 32'(i == 0));
            check($sformatf("%s b%0d ch_idx", tag, i), 32'(obs_ch), 32'(i / 8));
            check($sformatf("%s b%0d underrun", tag, i), 32'(obs_under),
                  32'((i == 0) ? exp_under : 1'b0));
            check($sformatf("%s b%0d in_ready", tag, i), 32'(obs_ready),
                  32'((offer && i >= 4) ? 1'b0 : 1'b1));
            if (offer && i == 3) begin
                in_valid = 1'b1;
                in_data  = offer_data;
            end
            if (offer && i == 4) in_valid = 1'b0;
            if (i == drop_at) en = 1'b0;
            tick();
        end
        for (int g = 0; g < gap; g++) begin
            check($sformatf("%s gap%0d serial", tag, g), 32'(obs_serial), 32'(0));
            check($sformatf("%s gap%0d sync", tag, g), 32'(obs_sync), 32'(0));
            check($sformatf("%s gap%0d ch_idx", tag, g), 32'(obs_ch), 32'(0));
            check($sformatf("%s gap%0d in_ready", tag, g), 32'(obs_ready),
                  32'(offer ? 1'b0 : 1'b1));
            tick();
        end
    endtask

    task automatic restart(input logic [1:0] which, input logic [23:0] data);
        sel      = which;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n    = 1'b1;
        en       = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = data;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        sel      = 2'd0;
        tick();
        tick();
        check("reset serial", 32'(obs_serial), 32'(0));
        check("reset sync", 32'(obs_sync), 32'(0));
        check("reset underrun", 32'(obs_under), 32'(0));
        check("reset ch_idx", 32'(obs_ch), 32'(0));
        check("reset in_ready", 32'(obs_ready), 32'(1));

        rst_n = 1'b1;
        tick();
        en       = 1'b1;
        in_valid = 1'b1;
        in_data  = 24'hF0CCAA;
        tick();
        in_valid = 1'b0;
        check("xfer in_ready", 32'(obs_ready), 32'(0));
        check("xfer idle serial", 32'(obs_serial), 32'(0));
        check("xfer idle sync", 32'(obs_sync), 32'(0));
        tick();

        frame_check("F1", 24'b10101010_11001100_11110000, 1'b0, 1'b0, 24'h0, -1, 0);
        frame_check("F2", 24'b10101010_11001100_11110000, 1'b1, 1'b1, 24'h030201, -1, 0);
        frame_check("F3", 24'b00000001_00000010_00000011, 1'b0, 1'b0, 24'h0, -1, 0);
        frame_check("F4", 24'b00000001_00000010_00000011, 1'b1, 1'b0, 24'h0, 10, 0);

        for (int i = 0; i < 4; i++) begin
            check($sformatf("idle%0d serial", i), 32'(obs_serial), 32'(0));
            check($sformatf("idle%0d sync", i), 32'(obs_sync), 32'(0));
            check($sformatf("idle%0d underrun", i), 32'(obs_under), 32'(0));
            tick();
        end
        in_valid = 1'b1;
        in_data  = 24'h5A3C81;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pend%0d serial", i), 32'(obs_serial), 32'(0));
            check($sformatf("pend%0d in_ready", i), 32'(obs_ready), 32'(0));
            tick();
        end
        en = 1'b1;
        tick();
        frame_check("F5", 24'b10000001_00111100_01011010, 1'b0, 1'b0, 24'h0, -1, 0);

        check("F6 underrun", 32'(obs_under), 32'(1));
        in_valid = 1'b1;
        in_data  = 24'h123456;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("F6 b5 in_ready", 32'(obs_ready), 32'(0));
        check("F6 b5 sync", 32'(obs_sync), 32'(0));
        rst_n = 1'b0;
        #1;
        check("async rst serial", 32'(obs_serial), 32'(0));
        check("async rst sync", 32'(obs_sync), 32'(0));
        check("async rst underrun", 32'(obs_under), 32'(0));
        check("async rst ch_idx", 32'(obs_ch), 32'(0));
        check("async rst in_ready", 32'(obs_ready), 32'(1));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check($sformatf("post rst%0d serial", i), 32'(obs_serial), 32'(0));
            check($sformatf("post rst%0d sync", i), 32'(obs_sync), 32'(0));
        end

        restart(2'd1, 24'hF0CCAA);
        frame_check("L1", 24'b01010101_00110011_00001111, 1'b0, 1'b0, 24'h0, -1, 0);

        restart(2'd2, 24'hF0CCAA);
        frame_check("G1", 24'b10101010_11001100_11110000, 1'b0, 1'b0, 24'h0, -1, 4);
        frame_check("G2", 24'b10101010_11001100_11110000, 1'b1, 1'b0, 24'h0, -1, 4);
        check("G3 sync", 32'(obs_sync), 32'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
